// File: rtl/bono_pkg.sv
// Shared types for the bono palette controller.
// Index/RGB widths, pixel struct and arbiter state.
package bono_pkg;

  localparam int PAL_IDX_W = 8;
  localparam int RGB_W     = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [PAL_IDX_W-1:0] addr;
    rgb_t                 data;
  } pal_wr_t;

  typedef enum logic {
    DISPLAY = 1'b0,
    COMMIT  = 1'b1
  } pal_state_t;

endpackage

// File: rtl/bono_wr_fifo.sv
// Palette write FIFO: binary pointers with an extra wrap bit.
// Flags come straight from the registered pointers.
module bono_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_one
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [AW:0]  w_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_cnt   = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_one   = (w_cnt == (AW+1)'(1));
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/bono_palette_ctrl.sv
// Palette RAM arbiter: display reads in active video,
// buffered host writes committed only during blanking.
module bono_palette_ctrl
  import bono_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit VB_ONLY = 1'b1
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic [PAL_IDX_W-1:0] index_in,
  output logic [RGB_W-1:0]     pixel_out,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [PAL_IDX_W-1:0] wr_addr,
  input  logic [RGB_W-1:0]     wr_data,
  output logic                 pending,
  output logic                 ram_we,
  output logic [PAL_IDX_W-1:0] ram_addr,
  output logic [RGB_W-1:0]     ram_din,
  input  logic [RGB_W-1:0]     ram_dout
);

  pal_state_t r_state;
  pal_state_t w_state_nx;
  pal_wr_t    w_wr;
  pal_wr_t    w_head;
  rgb_t       r_pix;
  logic       r_blank_d1;
  logic       w_blank;
  logic       w_commit_ok;
  logic       w_full;
  logic       w_empty;
  logic       w_one;
  logic       w_push;
  logic       w_we;

  assign w_blank     = hblank | vblank;
  assign w_commit_ok = VB_ONLY ? vblank : w_blank;

  assign w_wr   = {wr_addr, wr_data};
  assign w_push = wr_valid & ~w_full;

  bono_wr_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(pal_wr_t))
  ) u_fifo (
    .i_clk   (pixel_clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_wr),
    .i_pop   (w_we),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_one   (w_one)
  );

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) r_state <= DISPLAY;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      DISPLAY: begin
        if (w_commit_ok && !w_empty) w_state_nx = COMMIT;
      end
      COMMIT: begin
        if (!w_commit_ok || w_empty || (w_one && !w_push))
          w_state_nx = DISPLAY;
      end
      default: w_state_nx = DISPLAY;
    endcase
  end

  // Display wins: a write is gated off the moment commit_ok drops.
  always_comb begin
    w_we = 1'b0;
    unique case (r_state)
      DISPLAY: w_we = 1'b0;
      COMMIT:  w_we = w_commit_ok & ~w_empty;
      default: w_we = 1'b0;
    endcase
  end

  assign ram_we   = w_we;
  assign ram_addr = w_we ? w_head.addr : index_in;
  assign ram_din  = w_head.data;
  assign wr_ready = ~w_full;
  assign pending  = ~w_empty;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_d1 <= 1'b1;
      r_pix      <= '0;
    end else begin
      r_blank_d1 <= w_blank;
      r_pix      <= r_blank_d1 ? rgb_t'('0) : rgb_t'(ram_dout);
    end
  end

  assign pixel_out = r_pix;

endmodule

// File: tb/tb_bono_palette_ctrl.sv
// Bench for bono_palette_ctrl: directed scenarios plus a
// randomized run against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_bono_palette_ctrl;

  localparam int DEPTH = 4;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic        hblank    = 1'b0;
  logic        vblank    = 1'b0;
  logic [7:0]  index_in  = '0;
  logic        wr_valid  = 1'b0;
  logic [7:0]  wr_addr   = '0;
  logic [23:0] wr_data   = '0;

  logic [23:0] pixel_out;
  logic        wr_ready;
  logic        pending;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [23:0] ram_din;
  logic [23:0] ram_dout;

  logic [23:0] a_pixel_out;
  logic        a_wr_ready;
  logic        a_pending;
  logic        a_ram_we;
  logic [7:0]  a_ram_addr;
  logic [23:0] a_ram_din;

  logic [23:0] ram  [256];
  logic [23:0] gmem [256];

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  bono_palette_ctrl #(.DEPTH(DEPTH), .VB_ONLY(1'b1)) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .hblank    (hblank),
    .vblank    (vblank),
    .index_in  (index_in),
    .pixel_out (pixel_out),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pending   (pending),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  bono_palette_ctrl #(.DEPTH(DEPTH), .VB_ONLY(1'b0)) dut_any (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .hblank    (hblank),
    .vblank    (vblank),
    .index_in  (index_in),
    .pixel_out (a_pixel_out),
    .wr_valid  (wr_valid),
    .wr_ready  (a_wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pending   (a_pending),
    .ram_we    (a_ram_we),
    .ram_addr  (a_ram_addr),
    .ram_din   (a_ram_din),
    .ram_dout  (24'h0)
  );

  // Palette RAM with a one-cycle registered, read-first port.
  always @(posedge pixel_clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Reference model: pending writes as a queue, palette as an array.
  logic [31:0] mq [$];
  bit          m_commit;
  bit          m_w;
  bit          m_p;
  int          m_pre;
  logic [23:0] e1;
  logic [23:0] e2;

  function automatic bit m_we();
    return m_commit && vblank && (mq.size() > 0);
  endfunction

  function automatic logic [7:0] m_addr();
    return m_we() ? mq[0][31:24] : index_in;
  endfunction

  always @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_commit = 1'b0;
      e1 = '0;
      e2 = '0;
    end else begin
      m_w   = m_we();
      m_pre = mq.size();
      m_p   = wr_valid && (m_pre < DEPTH);
      e2 = e1;
      e1 = (hblank | vblank) ? 24'h0 : gmem[index_in];
      if (m_w) begin
        gmem[mq[0][31:24]] = mq[0][23:0];
        void'(mq.pop_front());
      end
      if (m_p) mq.push_back({wr_addr, wr_data});
      if (m_commit) m_commit = vblank && (mq.size() > 0);
      else          m_commit = vblank && (m_pre > 0);
    end
  end

  task automatic adv();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge pixel_clk);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    hblank   = 1'b0;
    vblank   = 1'b0;
    reset_n  = 1'b0;
    repeat (2) adv();
    reset_n = 1'b1;
    adv();
  endtask

  task automatic push(input logic [7:0] a, input logic [23:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    adv();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    index_in = 8'h3C;
    repeat (2) adv();
    smp();
    checks++; if (pixel_out !== 24'h0) begin errors++; $display("FAIL rst_pix got %h want 000000", pixel_out); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", ram_we); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", pending); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", wr_ready); end
    checks++; if (ram_addr !== 8'h3C) begin errors++; $display("FAIL rst_addr got %h want 3c", ram_addr); end
    reset_n = 1'b1;
    adv();
  endtask

  task automatic test_display();
    do_reset();
    index_in = 8'h05;
    smp();
    checks++; if (ram_addr !== 8'h05) begin errors++; $display("FAIL disp_addr got %h want 05", ram_addr); end
    adv();
    index_in = 8'h06;
    adv();
    index_in = 8'h07;
    smp();
    checks++; if (pixel_out !== 24'hFF0000) begin errors++; $display("FAIL disp_pix5 got %h want ff0000", pixel_out); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL disp_we got %b want 0", ram_we); end
    adv();
    smp();
    checks++; if (pixel_out !== gmem[8'h06]) begin errors++; $display("FAIL disp_pix6 got %h want %h", pixel_out, gmem[8'h06]); end
    adv();
  endtask

  task automatic test_commit_vblank();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 8'h10 + 8'(i);
      wr_data  = 24'h111111 * 24'(i + 1);
      smp();
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cv_fill_we[%0d] got %b want 0", i, ram_we); end
      adv();
    end
    wr_valid = 1'b0;
    smp();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL cv_ready got %b want 0", wr_ready); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL cv_pending got %b want 1", pending); end
    adv();
    vblank = 1'b1;
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL cv_enter_we got %b want 0", ram_we); end
    adv();
    for (int k = 0; k < 4; k++) begin
      smp();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 8'h10 + 8'(k) ||
          ram_din !== 24'h111111 * 24'(k + 1)) begin
        errors++;
        $display("FAIL cv_write[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 k, ram_we, ram_addr, ram_din, 8'h10 + 8'(k), 24'h111111 * 24'(k + 1));
      end
      adv();
    end
    smp();
    checks++; if (ram_we !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL cv_done got we=%b pend=%b want 0 0", ram_we, pending); end
    adv();
    vblank   = 1'b0;
    index_in = 8'h12;
    adv();
    adv();
    smp();
    checks++; if (pixel_out !== 24'h333333) begin errors++; $display("FAIL cv_read12 got %h want 333333", pixel_out); end
    adv();
  endtask

  task automatic test_vb_only();
    do_reset();
    push(8'h30, 24'h123456);
    hblank = 1'b1;
    smp();
    checks++; if (ram_we !== 1'b0 || a_ram_we !== 1'b0) begin errors++; $display("FAIL vb_h0 got we=%b any=%b want 0 0", ram_we, a_ram_we); end
    adv();
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL vb_only_we got %b want 0", ram_we); end
    checks++;
    if (a_ram_we !== 1'b1 || a_ram_addr !== 8'h30 || a_ram_din !== 24'h123456) begin
      errors++;
      $display("FAIL vb_any_write got we=%b a=%h d=%h want 1 30 123456", a_ram_we, a_ram_addr, a_ram_din);
    end
    adv();
    smp();
    checks++; if (pending !== 1'b1 || a_pending !== 1'b0) begin errors++; $display("FAIL vb_pend got %b any=%b want 1 0", pending, a_pending); end
    hblank = 1'b0;
    adv();
  endtask

  task automatic test_partial();
    do_reset();
    push(8'h40, 24'hABCDEF);
    push(8'h41, 24'h13579B);
    vblank = 1'b1;
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL pt_enter got %b want 0", ram_we); end
    adv();
    smp();
    checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h40) begin errors++; $display("FAIL pt_first got we=%b a=%h want 1 40", ram_we, ram_addr); end
    adv();
    vblank = 1'b0;
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL pt_drop got %b want 0", ram_we); end
    for (int i = 0; i < 3; i++) begin
      adv();
      smp();
      checks++; if (pending !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL pt_hold[%0d] got pend=%b we=%b want 1 0", i, pending, ram_we); end
    end
    adv();
    vblank = 1'b1;
    smp();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL pt_reenter got %b want 0", ram_we); end
    adv();
    smp();
    checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h41 || ram_din !== 24'h13579B) begin errors++; $display("FAIL pt_second got we=%b a=%h d=%h want 1 41 13579b", ram_we, ram_addr, ram_din); end
    adv();
    smp();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL pt_empty got %b want 0", pending); end
    adv();
    vblank = 1'b0;
  endtask

  task automatic test_reset_commit();
    int n;
    do_reset();
    push(8'h50, 24'h0F0F0F);
    push(8'h51, 24'h1E1E1E);
    push(8'h52, 24'h2D2D2D);
    vblank = 1'b1;
    n = 0;
    smp();
    while (ram_we !== 1'b1 && n < 10) begin
      adv();
      smp();
      n++;
    end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rc_wait got %b want 1 within 10 cycles", ram_we); end
    reset_n  = 1'b0;
    index_in = 8'h77;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rc_we got %b want 0", ram_we); end
    checks++; if (pending !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rc_flags got pend=%b rdy=%b want 0 1", pending, wr_ready); end
    checks++; if (ram_addr !== 8'h77) begin errors++; $display("FAIL rc_addr got %h want 77", ram_addr); end
    adv();
    adv();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      checks++; if (ram_we !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL rc_after[%0d] got we=%b pend=%b want 0 0", i, ram_we, pending); end
      adv();
    end
    vblank = 1'b0;
  endtask

  task automatic test_same_addr();
    do_reset();
    push(8'h20, 24'hAAAAAA);
    push(8'h20, 24'hBBBBBB);
    vblank = 1'b1;
    repeat (4) adv();
    vblank   = 1'b0;
    index_in = 8'h20;
    adv();
    adv();
    smp();
    checks++; if (pixel_out !== 24'hBBBBBB) begin errors++; $display("FAIL sa_pix got %h want bbbbbb", pixel_out); end
    adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      index_in = 8'($urandom);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 8'($urandom);
      wr_data  = 24'($urandom);
      hblank   = ((c % 16) >= 13);
      vblank   = ((c % 90) >= 78) ^ ($urandom_range(0, 19) == 0);
      smp();
      checks++; if (ram_we !== m_we()) begin errors++; $display("FAIL rnd_we c=%0d got %b want %b", c, ram_we, m_we()); end
      checks++; if (ram_addr !== m_addr()) begin errors++; $display("FAIL rnd_addr c=%0d got %h want %h", c, ram_addr, m_addr()); end
      if (m_we()) begin
        checks++; if (ram_din !== mq[0][23:0]) begin errors++; $display("FAIL rnd_din c=%0d got %h want %h", c, ram_din, mq[0][23:0]); end
      end
      checks++; if (pending !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_pend c=%0d got %b want %b", c, pending, mq.size() > 0); end
      checks++; if (wr_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, wr_ready, mq.size() < DEPTH); end
      checks++; if (pixel_out !== e2) begin errors++; $display("FAIL rnd_pix c=%0d got %h want %h", c, pixel_out, e2); end
      adv();
    end
    wr_valid = 1'b0;
    hblank   = 1'b0;
    vblank   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = 24'($urandom);
      gmem[i] = ram[i];
    end
    ram[8'h05]  = 24'hFF0000;
    gmem[8'h05] = 24'hFF0000;
    test_reset();
    test_display();
    test_commit_vblank();
    test_vb_only();
    test_partial();
    test_reset_commit();
    test_same_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
